// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes and controller states.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_INC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_DEC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOR = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_SAR = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_comb.sv
// Single-cycle ALU datapath and flags; MUL is produced by the sequencer, not here.
module alu_seq_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic             n,
    output logic             err
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [SHW-1:0]     sh;
    logic [WIDTH:0]     shl_w;
    logic [WIDTH:0]     shr_w;
    logic signed [WIDTH:0] sar_w;

    assign b_eff = (op == OP_INC || op == OP_DEC) ? WIDTH'(1) : b;
    assign sum   = {1'b0, a} + {1'b0, b_eff};
    assign diff  = {1'b0, a} - {1'b0, b_eff};
    assign sh    = b[SHW-1:0];
    // An extra guard bit on each shift catches the last bit shifted out.
    assign shl_w = {1'b0, a} << sh;
    assign shr_w = {a, 1'b0} >> sh;
    assign sar_w = $signed({a, 1'b0}) >>> sh;

    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        err   = 1'b0;
        case (op)
            OP_ADD, OP_INC: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_DEC: begin
                res   = diff[WIDTH-1:0];
                carry = diff[WIDTH];
                ovf   = (a[WIDTH-1] != b_eff[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOR: res = ~(a | b);
            OP_SHL: begin
                res   = shl_w[WIDTH-1:0];
                carry = shl_w[WIDTH];
            end
            OP_SHR: begin
                res   = shr_w[WIDTH:1];
                carry = shr_w[0];
            end
            OP_SAR: begin
                res   = sar_w[WIDTH:1];
                carry = sar_w[0];
            end
            OP_MUL: res = '0;
            default: err = 1'b1;
        endcase
        zero = !err && (res == '0);
        n    = res[WIDTH-1];
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops register straight to HOLD, MUL iterates one bit per cycle.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic             N,
    output logic             err
);
    localparam int SHW = $clog2(WIDTH);

    state_t               state_reg;
    logic                 in_ready_reg;
    logic                 out_valid_reg;
    logic [WIDTH-1:0]     out_reg;
    logic                 carry_reg;
    logic                 ovf_reg;
    logic                 zero_reg;
    logic                 n_reg;
    logic                 err_reg;
    logic [SHW-1:0]       cnt_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [2*WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]     mplier_reg;
    logic [2*WIDTH-1:0]   acc_next;

    logic [WIDTH-1:0]     c_res;
    logic                 c_carry;
    logic                 c_ovf;
    logic                 c_zero;
    logic                 c_n;
    logic                 c_err;

    alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
        .op    (op),
        .a     (in0),
        .b     (in1),
        .res   (c_res),
        .carry (c_carry),
        .ovf   (c_ovf),
        .zero  (c_zero),
        .n     (c_n),
        .err   (c_err)
    );

    assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
            carry_reg     <= 1'b0;
            ovf_reg       <= 1'b0;
            zero_reg      <= 1'b0;
            n_reg         <= 1'b0;
            err_reg       <= 1'b0;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_reg <= 1'b0;
                        if (op == OP_MUL) begin
                            mcand_reg  <= {{WIDTH{1'b0}}, in0};
                            mplier_reg <= in1;
                            acc_reg    <= '0;
                            cnt_reg    <= '0;
                            state_reg  <= BUSY;
                        end else begin
                            out_reg       <= c_res;
                            carry_reg     <= c_carry;
                            ovf_reg       <= c_ovf;
                            zero_reg      <= c_zero;
                            n_reg         <= c_n;
                            err_reg       <= c_err;
                            out_valid_reg <= 1'b1;
                            state_reg     <= HOLD;
                        end
                    end
                end
                BUSY: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 1'b1;
                    // Last iteration publishes the product directly from acc_next.
                    if (&cnt_reg) begin
                        out_reg       <= acc_next[WIDTH-1:0];
                        carry_reg     <= |acc_next[2*WIDTH-1:WIDTH];
                        ovf_reg       <= 1'b0;
                        zero_reg      <= (acc_next[WIDTH-1:0] == '0);
                        n_reg         <= acc_next[WIDTH-1];
                        err_reg       <= 1'b0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out       = out_reg;
    assign carryout  = carry_reg;
    assign overflow  = ovf_reg;
    assign zero      = zero_reg;
    assign N         = n_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed plus random checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] in0 = '0;
    logic [31:0] in1 = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out;
    logic        carryout;
    logic        overflow;
    logic        zero;
    logic        N;
    logic        err;

    int checks = 0;
    int fails  = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in0       (in0),
        .in1       (in1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .carryout  (carryout),
        .overflow  (overflow),
        .zero      (zero),
        .N         (N),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        longint s;
        longint unsigned p;
        logic signed [31:0] t;
        int sh;
        r  = '0;
        sh = int'(b[4:0]);
        if (o == OP_INC || o == OP_DEC) b = 32'd1;
        case (o)
            OP_ADD, OP_INC: begin
                p = 64'(a) + 64'(b);
                r.res = p[31:0];
                r.c = p[32];
                s = longint'($signed(a)) + longint'($signed(b));
                t = s[31:0];
                r.v = (longint'(t) != s);
            end
            OP_SUB, OP_DEC: begin
                r.res = a - b;
                r.c = (a < b);
                s = longint'($signed(a)) - longint'($signed(b));
                t = s[31:0];
                r.v = (longint'(t) != s);
            end
            OP_AND: r.res = a & b;
            OP_OR:  r.res = a | b;
            OP_XOR: r.res = a ^ b;
            OP_NOR: r.res = ~(a | b);
            OP_SHL: begin
                r.res = a << sh;
                r.c = (sh == 0) ? 1'b0 : a[32 - sh];
            end
            OP_SHR: begin
                r.res = a >> sh;
                r.c = (sh == 0) ? 1'b0 : a[sh - 1];
            end
            OP_SAR: begin
                r.res = 32'($signed(a) >>> sh);
                r.c = (sh == 0) ? 1'b0 : a[sh - 1];
            end
            OP_MUL: begin
                p = 64'(a) * 64'(b);
                r.res = p[31:0];
                r.c = (p[63:32] != 0);
            end
            default: r.e = 1'b1;
        endcase
        if (!r.e) begin
            r.z = (r.res == 0);
            r.n = r.res[31];
        end
        return r;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out"}, out, 32'd0);
        check({tag, "_flags"}, {27'd0, carryout, overflow, zero, N, err}, 32'd0);
    endtask

    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
        exp_t e;
        int lat;
        int busy_low;
        e = model(o, a, b);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op = o;
        in0 = a;
        in1 = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 4'($urandom);
        in0 = $urandom;
        in1 = $urandom;
        lat = 1;
        busy_low = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) busy_low++;
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), (o == OP_MUL) ? 32'd33 : 32'd1);
        check("busy_in_ready_low", 32'(busy_low), (o == OP_MUL) ? 32'd32 : 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            in0 = $urandom;
            in1 = $urandom;
            check("hold_out", out, e.res);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("out", out, e.res);
        check("carryout", 32'(carryout), 32'(e.c));
        check("overflow", 32'(overflow), 32'(e.v));
        check("zero", 32'(zero), 32'(e.z));
        check("N", 32'(N), 32'(e.n));
        check("err", 32'(err), 32'(e.e));
        check("in_ready_hold", 32'(in_ready), 32'd0);
        $display("op=%0d in0=%h in1=%h -> out=%h c=%b v=%b z=%b n=%b err=%b lat=%0d",
                 o, a, b, out, carryout, overflow, zero, N, err, lat);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("released_out_valid", 32'(out_valid), 32'd0);
        check("released_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [3:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        run_op(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        check("add_literal", out, 32'h8000_0000);
        run_op(OP_SUB, 32'h0000_0005, 32'h0000_0005, 0);
        run_op(OP_SUB, 32'h0000_0001, 32'h0000_0002, 0);
        check("sub_literal", out, 32'hFFFF_FFFF);
        run_op(OP_SAR, 32'h8000_0000, 32'd4, 0);
        check("sar_literal", out, 32'hF800_0000);
        run_op(OP_SHL, 32'h8000_0001, 32'd1, 0);
        run_op(OP_SHR, 32'h0000_00F0, 32'd0, 0);
        run_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, 0);
        run_op(OP_MUL, 32'd7, 32'd6, 10);
        check("mul_literal", out, 32'd42);

        // Abort a multiply in its tenth busy cycle.
        @(negedge clk);
        in_valid = 1'b1;
        op = OP_MUL;
        in0 = 32'h1234_5678;
        in1 = 32'h0000_0FFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("busy_reset");
        @(negedge clk);
        rst = 1'b0;

        run_op(4'd14, 32'hDEAD_BEEF, 32'h1, 0);
        run_op(OP_INC, 32'hFFFF_FFFF, 32'h0, 0);
        run_op(OP_DEC, 32'h8000_0000, 32'h0, 0);

        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(0, 31)) : $urandom;
            run_op(ro, ra, rb, i % 4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
